// File: rtl/shf_ctrl_pkg.sv
// rtl/shf_ctrl_pkg.sv - opcode, shifter class and state definitions for the shifter controller
package shf_ctrl_pkg;

  localparam logic [2:0] OP_ASHIFT = 3'b000;
  localparam logic [2:0] OP_ROT    = 3'b001;
  localparam logic [2:0] OP_LEFTZ  = 3'b010;
  localparam logic [2:0] OP_LEFTO  = 3'b011;
  localparam logic [2:0] OP_NORM   = 3'b100;

  localparam logic [1:0] CLS_ASH = 2'b00;
  localparam logic [1:0] CLS_ROT = 2'b01;
  localparam logic [1:0] CLS_LZ  = 2'b10;
  localparam logic [1:0] CLS_LO  = 2'b11;

  localparam logic [4:0] NORM_ZERO_CNT = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ISSUE2,
    WAIT2,
    RESP
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_NORM;
  endfunction

  // NORM starts with a leading-zero count pass.
  function automatic logic [1:0] op_cls(input logic [2:0] op);
    return (op == OP_NORM) ? CLS_LZ : op[1:0];
  endfunction

endpackage

// File: rtl/shf_rr_arb.sv
// rtl/shf_rr_arb.sv - two-way round-robin grant; priority flips only on an accepted grant
module shf_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic pref1;

  always_comb begin
    gnt0 = req0 && (!req1 || !pref1);
    gnt1 = req1 && (!req0 || pref1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pref1 <= 1'b0;
    end else if (accept) begin
      pref1 <= gnt0;
    end
  end

endmodule

// File: rtl/shf_ctrl.sv
// rtl/shf_ctrl.sv - shares one shifter between two requesters, sequences single-pass ops and two-pass NORM
module shf_ctrl
  import shf_ctrl_pkg::*;
#(
  parameter int DATASIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_req_valid,
  output logic                r0_req_ready,
  input  logic [2:0]          r0_req_op,
  input  logic [DATASIZE-1:0] r0_req_x,
  input  logic [DATASIZE-1:0] r0_req_y,
  input  logic                r1_req_valid,
  output logic                r1_req_ready,
  input  logic [2:0]          r1_req_op,
  input  logic [DATASIZE-1:0] r1_req_x,
  input  logic [DATASIZE-1:0] r1_req_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATASIZE-1:0] rsp_dt,
  output logic                rsp_sv,
  output logic                rsp_sz,
  output logic [4:0]          rsp_cnt,
  output logic                rsp_err,
  output logic                ctl_shf_en,
  output logic [1:0]          ctl_shf_cls,
  output logic [DATASIZE-1:0] ctl_dtx,
  output logic [DATASIZE-1:0] ctl_dty,
  input  logic [DATASIZE-1:0] shf_xb_dt,
  input  logic                shf_ps_sv,
  input  logic                shf_ps_sz
);

  state_t              state, state_n;
  logic [2:0]          op_q;
  logic                gnt0, gnt1, acc, in_idle;
  logic [2:0]          acc_op;
  logic [DATASIZE-1:0] acc_x, acc_y;
  logic [4:0]          norm_c;

  assign in_idle = (state == IDLE) && !reset;

  shf_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (r0_req_valid && in_idle),
    .req1   (r1_req_valid && in_idle),
    .accept (acc),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign r0_req_ready = gnt0;
  assign r1_req_ready = gnt1;
  assign acc          = gnt0 | gnt1;
  assign acc_op       = gnt1 ? r1_req_op : r0_req_op;
  assign acc_x        = gnt1 ? r1_req_x  : r0_req_x;
  assign acc_y        = gnt1 ? r1_req_y  : r0_req_y;
  assign norm_c       = shf_xb_dt[4:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (acc) state_n = op_legal(acc_op) ? ISSUE : RESP;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = (op_q == OP_NORM && norm_c != NORM_ZERO_CNT) ? ISSUE2 : RESP;
      ISSUE2:  state_n = WAIT2;
      WAIT2:   state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_dt      <= '0;
      rsp_sv      <= 1'b0;
      rsp_sz      <= 1'b0;
      rsp_cnt     <= '0;
      rsp_err     <= 1'b0;
      ctl_shf_en  <= 1'b0;
      ctl_shf_cls <= '0;
      ctl_dtx     <= '0;
      ctl_dty     <= '0;
    end else begin
      state      <= state_n;
      ctl_shf_en <= (state_n == ISSUE) || (state_n == ISSUE2);
      case (state)
        IDLE: if (acc) begin
          op_q        <= acc_op;
          ctl_shf_cls <= op_cls(acc_op);
          ctl_dtx     <= acc_x;
          ctl_dty     <= acc_y;
          rsp_id      <= gnt1;
          rsp_err     <= !op_legal(acc_op);
          rsp_valid   <= !op_legal(acc_op);
          rsp_dt      <= '0;
          rsp_sv      <= 1'b0;
          rsp_sz      <= 1'b0;
          rsp_cnt     <= '0;
        end
        WAIT: begin
          if (op_q != OP_NORM) begin
            rsp_dt    <= shf_xb_dt;
            rsp_sv    <= shf_ps_sv;
            rsp_sz    <= shf_ps_sz;
            rsp_valid <= 1'b1;
          end else if (norm_c == NORM_ZERO_CNT) begin
            rsp_sz    <= 1'b1;
            rsp_cnt   <= NORM_ZERO_CNT;
            rsp_valid <= 1'b1;
          end else begin
            ctl_shf_cls <= CLS_ASH;
            ctl_dty     <= {{(DATASIZE-5){1'b0}}, norm_c};
          end
        end
        WAIT2: begin
          // ctl_dty still carries the leading-zero count from the second issue.
          rsp_dt    <= shf_xb_dt;
          rsp_sv    <= shf_ps_sv;
          rsp_sz    <= shf_ps_sz;
          rsp_cnt   <= ctl_dty[4:0];
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shf_ctrl.sv
// tb/tb_shf_ctrl.sv - self-checking bench for shf_ctrl with behavioural shifter and reference model
module tb_shf_ctrl;
  import shf_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req_valid = 1'b0, r1_req_valid = 1'b0;
  logic        r0_req_ready, r1_req_ready;
  logic [2:0]  r0_req_op = '0, r1_req_op = '0;
  logic [15:0] r0_req_x = '0, r0_req_y = '0, r1_req_x = '0, r1_req_y = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_sv, rsp_sz, rsp_err;
  logic [15:0] rsp_dt;
  logic [4:0]  rsp_cnt;
  logic        ctl_shf_en;
  logic [1:0]  ctl_shf_cls;
  logic [15:0] ctl_dtx, ctl_dty;
  logic [15:0] shf_xb_dt;
  logic        shf_ps_sv, shf_ps_sz;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  shf_ctrl #(.DATASIZE(16)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_op(r0_req_op),
    .r0_req_x(r0_req_x), .r0_req_y(r0_req_y),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_op(r1_req_op),
    .r1_req_x(r1_req_x), .r1_req_y(r1_req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dt(rsp_dt),
    .rsp_sv(rsp_sv), .rsp_sz(rsp_sz), .rsp_cnt(rsp_cnt), .rsp_err(rsp_err),
    .ctl_shf_en(ctl_shf_en), .ctl_shf_cls(ctl_shf_cls), .ctl_dtx(ctl_dtx), .ctl_dty(ctl_dty),
    .shf_xb_dt(shf_xb_dt), .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clz(input logic [15:0] v);
    int n = 0;
    for (int i = 15; i >= 0 && !v[i]; i--) n++;
    return n;
  endfunction

  // Shifter behaviour: returns {dt, sv, sz}.
  function automatic logic [17:0] shf_fn(input logic [1:0] cls, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] dt;
    logic [31:0] rr;
    logic sv;
    int n, amt;
    longint full;
    sv = 1'b0;
    n = $signed(y);
    case (cls)
      2'b00: begin
        amt = (n < 0) ? -n : n;
        if (amt > 16) amt = 16;
        if (n >= 0) begin
          full = longint'($signed(x)) <<< amt;
          dt = full[15:0];
          sv = (full != longint'($signed(dt)));
        end else begin
          full = longint'($signed(x)) >>> amt;
          dt = full[15:0];
        end
      end
      2'b01: begin
        rr = {x, x} << y[3:0];
        dt = rr[31:16];
      end
      2'b10: dt = 16'(clz(x));
      default: dt = 16'(clz(~x));
    endcase
    return {dt, sv, (dt == 16'h0000)};
  endfunction

  logic [1:0]  sh_cls = '0;
  logic [15:0] sh_x = '0, sh_y = '0;
  always @(posedge clk) if (ctl_shf_en) begin
    sh_cls <= ctl_shf_cls;
    sh_x   <= ctl_dtx;
    sh_y   <= ctl_dty;
  end
  assign {shf_xb_dt, shf_ps_sv, shf_ps_sz} = shf_fn(sh_cls, sh_x, sh_y);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  // Reference model: one outstanding op, expected response and shifter issues.
  logic        busy = 1'b0, pref1 = 1'b0;
  int          t_acc = 0, e_lat = 0;
  logic        e_two, e_ill, e_id, e_sv, e_sz, e_err;
  logic [15:0] e_dt, e_x, e_y;
  logic [4:0]  e_cnt;
  logic [1:0]  e_cls1;
  logic        m_r0, m_r1, m_en, m_rv;
  int          en_pulses = 0;

  task automatic model_accept(input logic id, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    int c;
    e_id = id; e_x = x; e_y = y; e_ill = 1'b0; e_two = 1'b0; e_cnt = '0; e_err = 1'b0;
    e_cls1 = op[1:0];
    if (op > 3'd4) begin
      e_ill = 1'b1; e_err = 1'b1; e_dt = '0; e_sv = 1'b0; e_sz = 1'b0; e_lat = 1;
    end else if (op == 3'd4) begin
      e_cls1 = 2'b10;
      c = clz(x);
      if (c == 16) begin
        e_dt = '0; e_sv = 1'b0; e_sz = 1'b1; e_cnt = 5'd16; e_lat = 3;
      end else begin
        {e_dt, e_sv, e_sz} = shf_fn(2'b00, x, 16'(c));
        e_cnt = 5'(c); e_two = 1'b1; e_lat = 5;
      end
    end else begin
      {e_dt, e_sv, e_sz} = shf_fn(op[1:0], x, y);
      e_lat = 3;
    end
  endtask

  always @(negedge clk) begin
    if (ctl_shf_en) en_pulses++;
    if (reset) begin
      busy = 1'b0;
      pref1 = 1'b0;
    end else begin
      m_r0 = !busy && r0_req_valid && (!r1_req_valid || !pref1);
      m_r1 = !busy && r1_req_valid && (!r0_req_valid || pref1);
      chk("req_ready", {r0_req_ready, r1_req_ready}, {m_r0, m_r1});
      m_en = busy && ((cyc == t_acc + 1 && !e_ill) || (cyc == t_acc + 3 && e_two));
      chk("shf_en", ctl_shf_en, m_en);
      if (m_en && cyc == t_acc + 1) chk("issue1", {ctl_shf_cls, ctl_dtx, ctl_dty}, {e_cls1, e_x, e_y});
      else if (m_en) chk("issue2", {ctl_shf_cls, ctl_dtx, ctl_dty}, {2'b00, e_x, 16'(e_cnt)});
      m_rv = busy && (cyc >= t_acc + e_lat);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv)
        chk("rsp_fields", {rsp_id, rsp_dt, rsp_sv, rsp_sz, rsp_cnt, rsp_err},
            {e_id, e_dt, e_sv, e_sz, e_cnt, e_err});
      if (m_rv && rsp_ready) begin
        busy = 1'b0;
      end else if (m_r0 || m_r1) begin
        pref1 = m_r0;
        if (m_r1) model_accept(1'b1, r1_req_op, r1_req_x, r1_req_y);
        else      model_accept(1'b0, r0_req_op, r0_req_x, r0_req_y);
        busy = 1'b1;
        t_acc = cyc;
      end
    end
  end

  task automatic drive(input logic rq, input logic v, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    if (rq) begin r1_req_valid = v; r1_req_op = op; r1_req_x = x; r1_req_y = y; end
    else    begin r0_req_valid = v; r0_req_op = op; r0_req_x = x; r0_req_y = y; end
  endtask

  task automatic send(input logic rq, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y, output int t);
    bit got;
    got = 0;
    t = 0;
    @(posedge clk); #1;
    drive(rq, 1'b1, op, x, y);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rq ? r1_req_ready : r0_req_ready) begin got = 1; t = cyc; end
    end
    @(posedge clk); #1;
    drive(rq, 1'b0, op, x, y);
    if (!got) fail("accept_wait");
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 0;
    t = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; t = cyc; end
    end
    if (!ok) fail("rsp_wait");
  endtask

  task automatic directed(input string nm, input logic rq, input logic [2:0] op, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] dt, input logic sv, input logic sz,
                          input logic [4:0] cnt, input logic err, input int lat, input int pulses);
    int ta, tr, p0;
    bit ok;
    p0 = en_pulses;
    send(rq, op, x, y, ta);
    wait_rsp(tr, ok);
    if (ok) begin
      chk({nm, "_latency"}, 64'(tr - ta), 64'(lat));
      chk({nm, "_rsp"}, {rsp_id, rsp_dt, rsp_sv, rsp_sz, rsp_cnt, rsp_err}, {rq, dt, sv, sz, cnt, err});
    end
    @(posedge clk); #1;
    chk({nm, "_en_pulses"}, 64'(en_pulses - p0), 64'(pulses));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [2:0] rnd_op();
    int v = int'($urandom % 10);
    return (v < 8) ? 3'(v % 5) : 3'(5 + $urandom % 3);
  endfunction

  function automatic logic [15:0] rnd_x();
    case ($urandom % 4)
      0: return 16'h0000;
      1: return 16'(1) << ($urandom % 16);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rnd_y();
    int n = int'($urandom_range(40)) - 20;
    return 16'(n);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tr, n;
    bit ok;
    logic [3:0] g;

    chk("pin_ashift", shf_fn(2'b00, 16'hF000, 16'hFFFC), {16'hFF00, 1'b0, 1'b0});
    chk("pin_rot", shf_fn(2'b01, 16'hC000, 16'h0002), {16'h0003, 1'b0, 1'b0});
    chk("pin_clz", 64'(clz(16'h0010)), 64'd11);
    chk("pin_norm2", shf_fn(2'b00, 16'h0010, 16'd11), {16'h8000, 1'b1, 1'b0});

    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {r0_req_ready, r1_req_ready, rsp_valid, rsp_id, rsp_dt, rsp_sv, rsp_sz, rsp_cnt,
                        rsp_err, ctl_shf_en, ctl_shf_cls, ctl_dtx, ctl_dty}, 64'd0);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    reset = 1'b0;

    directed("ashift", 1'b0, OP_ASHIFT, 16'hF000, 16'hFFFC, 16'hFF00, 1'b0, 1'b0, 5'd0, 1'b0, 3, 1);
    directed("rot", 1'b1, OP_ROT, 16'hC000, 16'h0002, 16'h0003, 1'b0, 1'b0, 5'd0, 1'b0, 3, 1);
    directed("norm", 1'b0, OP_NORM, 16'h0010, 16'h1234, 16'h8000, 1'b1, 1'b0, 5'd11, 1'b0, 5, 2);
    directed("norm_zero", 1'b1, OP_NORM, 16'h0000, 16'h0007, 16'h0000, 1'b0, 1'b1, 5'd16, 1'b0, 3, 1);
    directed("illegal", 1'b0, 3'b110, 16'hABCD, 16'h0003, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b1, 1, 0);

    // Both requesters held valid straight after reset.
    do_reset();
    drive(1'b0, 1'b1, OP_ASHIFT, 16'h0001, 16'h0001);
    drive(1'b1, 1'b1, OP_ROT, 16'h0002, 16'h0001);
    n = 0;
    g = '0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (r0_req_ready || r1_req_ready) begin
        g[3 - n] = r1_req_ready;
        n++;
      end
    end
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    if (n < 4) fail("rr_grants");
    else chk("rr_order", g, 4'b0101);
    repeat (8) @(posedge clk);

    // Response back-pressure with r1 waiting.
    #1;
    rsp_ready = 1'b0;
    send(1'b0, OP_ROT, 16'h00F0, 16'h0004, ta);
    drive(1'b1, 1'b1, OP_ASHIFT, 16'h0001, 16'h0001);
    wait_rsp(tr, ok);
    if (ok) begin
      chk("bp_latency", 64'(tr - ta), 64'd3);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        chk("bp_hold", {rsp_valid, rsp_dt, rsp_id, r1_req_ready, ctl_shf_en},
            {1'b1, 16'h0F00, 1'b0, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_accept", r1_req_ready, 1'b1);
    end
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(tr, ok);
    if (ok) chk("bp_r1_rsp", {rsp_id, rsp_dt}, {1'b1, 16'h0002});
    repeat (4) @(posedge clk);

    // Reset while the shifter result is pending.
    send(1'b0, OP_ASHIFT, 16'h1234, 16'h0003, ta);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_ASHIFT, 16'h0003, 16'h0001);
    drive(1'b1, 1'b1, OP_ASHIFT, 16'h0005, 16'h0001);
    reset = 1'b1;
    #1;
    chk("reset_abort", {r0_req_ready, r1_req_ready, rsp_valid, rsp_id, rsp_dt, rsp_sv, rsp_sz, rsp_cnt,
                        rsp_err, ctl_shf_en, ctl_shf_cls, ctl_dtx, ctl_dty}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_grant", {r0_req_ready, r1_req_ready}, 2'b10);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (8) @(posedge clk);

    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      drive(1'b0, ($urandom % 3) != 0, rnd_op(), rnd_x(), rnd_y());
      drive(1'b1, ($urandom % 3) != 0, rnd_op(), rnd_x(), rnd_y());
      rsp_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
